// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes and FSM state type shared by the alu_mc execute unit
package alu_pkg;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLL  = 6'h01;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLT  = 6'h2a;
    localparam logic [5:0] FUNCT_SLTU = 6'h2b;
    localparam logic [5:0] FUNCT_MUL  = 6'h2c;
    localparam logic [5:0] FUNCT_DIV  = 6'h1a;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } alu_state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - WIDTH-cycle shift-add multiplier / restoring divider (divider only with ALU_DIV_EN)
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] cur_hi, cur_lo, cur_b;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [WIDTH:0]   add_sum;

    // The first step runs on the accept edge straight from the operands,
    // so WIDTH steps finish in time for the DONE transition on edge t+WIDTH.
    assign cur_hi  = start ? '0  : hi;
    assign cur_lo  = start ? op1 : lo;
    assign cur_b   = start ? op2 : b_q;
    assign add_sum = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);

`ifdef ALU_DIV_EN
    logic             div_q, cur_div;
    logic [WIDTH:0]   div_shift, div_diff;

    assign cur_div   = start ? is_div : div_q;
    assign div_shift = {cur_hi, cur_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, cur_b};

    // One iteration step: restoring subtract (quotient bit into lo) or shift-add
    always_comb begin
        nxt_hi = '0;
        nxt_lo = '0;
        if (cur_div) begin
            if (!div_diff[WIDTH]) begin
                nxt_hi = div_diff[WIDTH-1:0];
                nxt_lo = {cur_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift[WIDTH-1:0];
                nxt_lo = {cur_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            {nxt_hi, nxt_lo} = {add_sum, cur_lo[WIDTH-1:1]};
        end
    end

    // Remember which operation is iterating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_q <= 1'b0;
        else if (start)
            div_q <= is_div;
    end
`else
    logic unused_is_div;
    assign unused_is_div = is_div;
    assign {nxt_hi, nxt_lo} = {add_sum, cur_lo[WIDTH-1:1]};
`endif

    // Accumulator / shift register update and remaining-step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            lo   <= '0;
            hi   <= '0;
            b_q  <= '0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                hi <= nxt_hi;
                lo <= nxt_lo;
            end
            if (start) begin
                busy <= 1'b1;
                cnt  <= CNT_W'(WIDTH - 1);
                b_q  <= op2;
            end else if (busy) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake; ALU_DIV_EN enables the divider
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               err
);
    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state;
    logic             accept, is_mul, is_div;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH-1:0] sc_res;
    logic             sc_err;
    logic [SH_W-1:0]  shamt;
    logic             dz_q;
    logic             unused_busy;

    assign accept      = (state == IDLE) && in_valid;
    assign is_mul      = (funct == FUNCT_W'(FUNCT_MUL));
    assign shamt       = op2[SH_W-1:0];
    assign unused_busy = md_busy;
`ifdef ALU_DIV_EN
    assign is_div      = (funct == FUNCT_W'(FUNCT_DIV));
`else
    assign is_div      = 1'b0;
`endif

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && (is_mul || is_div)),
        .is_div (is_div),
        .op1    (op1),
        .op2    (op2),
        .busy   (md_busy),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    // Single-cycle ops; anything not recognised flags an error with a zero result
    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (funct)
            FUNCT_W'(FUNCT_ADD):  sc_res = op1 + op2;
            FUNCT_W'(FUNCT_SUB):  sc_res = op1 - op2;
            FUNCT_W'(FUNCT_AND):  sc_res = op1 & op2;
            FUNCT_W'(FUNCT_OR):   sc_res = op1 | op2;
            FUNCT_W'(FUNCT_NOR):  sc_res = ~(op1 | op2);
            FUNCT_W'(FUNCT_SLL):  sc_res = op1 << shamt;
            FUNCT_W'(FUNCT_SRL):  sc_res = op1 >> shamt;
            FUNCT_W'(FUNCT_SRA):  sc_res = $signed(op1) >>> shamt;
            FUNCT_W'(FUNCT_SLT):  sc_res = WIDTH'($signed(op1) < $signed(op2));
            FUNCT_W'(FUNCT_SLTU): sc_res = WIDTH'(op1 < op2);
            FUNCT_W'(FUNCT_MUL):  sc_res = '0;
`ifdef ALU_DIV_EN
            FUNCT_W'(FUNCT_DIV):  sc_res = '0;
`endif
            default:              sc_err = 1'b1;
        endcase
    end

`ifdef ALU_DIV_EN
    // Divide-by-zero is flagged at acceptance; the iteration itself yields all-ones / op1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dz_q <= 1'b0;
        else if (accept)
            dz_q <= (op2 == '0);
    end
`else
    assign dz_q = 1'b0;
`endif

    // Handshake FSM with registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_mul) begin
                            state <= MUL;
                        end else if (is_div) begin
                            state <= DIV;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            result_hi <= '0;
                            zero      <= (sc_res == '0);
                            err       <= sc_err;
                        end
                    end
                end
                MUL, DIV: begin
                    if (md_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= md_lo;
                        result_hi <= md_hi;
                        zero      <= (md_lo == '0);
                        err       <= (state == DIV) && dz_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1, op2;
    logic [5:0]  funct;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result, result_hi;
    logic        zero, err;

    int total  = 0;
    int passed = 0;
    int lat;

    alu_mc #(.WIDTH(32), .FUNCT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .funct     (funct),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            passed++;
    endtask

    // Present one request for a single edge, scramble inputs, then count cycles to out_valid
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        funct    = f;
        op1      = a;
        op2      = b;
        @(negedge clk);
        in_valid = 1'b0;
        funct    = 6'h20;
        op1      = 32'hDEADBEEF;
        op2      = 32'h12345678;
        lat      = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic single(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err);
        issue(f, a, b);
        check({tag, "_lat"}, 64'(lat), 64'd0);
        check({tag, "_res"}, {32'd0, result}, {32'd0, exp_res});
        check({tag, "_hi_err_zero"}, {result_hi, 30'd0, err, zero},
              {32'd0, 30'd0, exp_err, (exp_res == 32'd0)});
        release_result();
    endtask

    task automatic multi(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic exp_err);
        issue(f, a, b);
        check({tag, "_lat"}, 64'(lat), 64'd32);
        check({tag, "_lo_hi"}, {result_hi, result}, {exp_hi, exp_lo});
        check({tag, "_err_zero"}, {62'd0, err, zero}, {62'd0, exp_err, (exp_lo == 32'd0)});
        release_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op1       = '0;
        op2       = '0;
        funct     = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_res", {result_hi, result}, 64'd0);
        check("rst_zero_err", {62'd0, zero, err}, 64'd0);
        rst_n = 1'b1;

        single("add_wrap", 6'h20, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        single("sub", 6'h22, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
        single("and", 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        single("or", 6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
        single("nor", 6'h27, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
        single("sll", 6'h01, 32'h1, 32'h3F, 32'h80000000, 1'b0);
        single("srl", 6'h02, 32'h80000000, 32'h4, 32'h08000000, 1'b0);
        single("sra", 6'h03, 32'h80000000, 32'h21, 32'hC0000000, 1'b0);
        single("slt", 6'h2a, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
        single("sltu", 6'h2b, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        single("illegal", 6'h3f, 32'h1234, 32'h5678, 32'h0, 1'b1);

        multi("mul_max", 6'h2c, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        multi("mul_small", 6'h2c, 32'h12345678, 32'h10, 32'h23456780, 32'h1, 1'b0);
        multi("mul_zero", 6'h2c, 32'h0, 32'h5, 32'h0, 32'h0, 1'b0);
`ifdef ALU_DIV_EN
        multi("div", 6'h1a, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        multi("div_zero", 6'h1a, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
`else
        single("div_off", 6'h1a, 32'd100, 32'd7, 32'h0, 1'b1);
`endif

        // Backpressure: result held, new requests ignored
        issue(6'h22, 32'd3, 32'd1);
        check("bp_lat", 64'(lat), 64'd0);
        in_valid = 1'b1;
        funct    = 6'h20;
        op1      = 32'd100;
        op2      = 32'd200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {28'd0, out_valid, in_ready, zero, err, result},
                  {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2});
        end
        in_valid = 1'b0;
        release_result();
        check("bp_release", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        @(negedge clk);
        check("bp_not_queued", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

        // Asynchronous reset in the middle of a multiply
        single("pre_rst_add", 6'h20, 32'd2, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        funct    = 6'h2c;
        op1      = 32'h0000FFFF;
        op2      = 32'h0000FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("mid_mul_busy", {62'd0, in_ready, out_valid}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready_valid", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        check("arst_res", {result_hi, result}, 64'd0);
        check("arst_zero_err", {62'd0, zero, err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        single("post_rst_add", 6'h20, 32'd7, 32'd8, 32'd15, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
